// File: rtl/rx_frame_controller.sv
// -----------------------------------------------------------------------------
// rx_frame_controller
//
// Frames the UART receive byte stream for the seven-segment display path.
// A frame is: SOF, LEN (1..MAX_LEN), LEN payload bytes, XOR checksum. The
// checksum covers the LEN byte and every payload byte. A verified payload is
// committed to the display register. A malformed, corrupted or stalled frame is
// rejected with an error pulse and code, and the display is left unchanged.
//
// Valid/ready: rx_rdy is a one-cycle valid strobe qualifying rx_data. The block
// has no ready signal. It accepts a byte in every cycle that rx_rdy is high and
// never back-pressures.
//
// Ports
//   clk        in   system clock (single clock domain)
//   rst        in   asynchronous, active-high reset
//   baud_en    in   16x-baud tick, one clk wide; paces the inter-byte timeout
//   rx_rdy     in   one-cycle strobe, rx_data valid
//   rx_data    in   received byte
//   display    out  committed payload, first payload byte most significant
//   frame_ok   out  one-cycle pulse when a frame is committed
//   frame_err  out  one-cycle pulse when a frame is rejected
//   err_code   out  last error: 0 none, 1 bad length, 2 checksum, 3 timeout
//   busy       out  high while a frame is in progress (state != IDLE)
//   frame_cnt  out  count of committed frames, wraps 255 -> 0
//   state_dbg  out  current FSM state (0 IDLE, 1 LEN, 2 PAYLOAD, 3 CHK)
// -----------------------------------------------------------------------------
module rx_frame_controller #(
    parameter logic [7:0] SOF           = 8'hA5,
    parameter int         MAX_LEN       = 2,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   baud_en,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic [8*MAX_LEN-1:0]   display,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy,
    output logic [7:0]             frame_cnt,
    output logic [1:0]             state_dbg
);

    localparam int DW = 8 * MAX_LEN;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHK     = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [DW-1:0]    shadow_q,    shadow_d;
    logic [DW-1:0]    display_q,   display_d;
    logic [7:0]       chk_q,       chk_d;
    logic [LW-1:0]    len_q,       len_d;
    logic [LW-1:0]    cnt_q,       cnt_d;
    logic [TW-1:0]    tick_q,      tick_d;
    logic             frame_ok_q,  frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q,  err_code_d;
    logic             busy_q,      busy_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic [DW-1:0]    shadow_shifted;
    logic [LW-1:0]    cnt_inc;
    logic             timeout_hit;

    // Shift the new byte in at the bottom so the first payload byte ends up in
    // the most significant position once the frame is complete.
    generate
        if (MAX_LEN == 1) begin : g_shift_single
            assign shadow_shifted = rx_data;
        end else begin : g_shift_multi
            assign shadow_shifted = {shadow_q[DW-9:0], rx_data};
        end
    endgenerate

    assign cnt_inc = cnt_q + 1'b1;

    // A byte arriving in the same cycle as the final tick wins: the counter
    // clears on rx_rdy, so the timeout is only taken when no byte is present.
    // The error fires on the edge that would have made the count equal
    // TIMEOUT_TICKS, so the counter itself never holds that value.
    assign timeout_hit = (state_q != S_IDLE) && !rx_rdy && baud_en &&
                         (tick_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        display_d   = display_q;
        chk_d       = chk_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tick_d      = tick_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;

        // Inter-byte tick counter.
        if ((state_q == S_IDLE) || rx_rdy) begin
            tick_d = '0;
        end else if (baud_en) begin
            tick_d = tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_rdy && (rx_data == SOF)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (rx_rdy) begin
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        len_d    = rx_data[LW-1:0];
                        chk_d    = rx_data;
                        shadow_d = '0;
                        cnt_d    = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                // SOF is ordinary data here; the frame length alone ends the
                // payload.
                if (rx_rdy) begin
                    shadow_d = shadow_shifted;
                    chk_d    = chk_q ^ rx_data;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end

            S_CHK: begin
                if (rx_rdy) begin
                    if (rx_data == chk_q) begin
                        display_d   = shadow_q;
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        err_code_d  = ERR_NONE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mutually exclusive with every rx_rdy branch above.
        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            display_q   <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tick_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            chk_q       <= chk_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign display   = display_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_controller
//
// Directed bench for rx_frame_controller with default parameters (SOF A5,
// MAX_LEN 2, TIMEOUT_TICKS 640). Inputs change on the falling edge and outputs
// are sampled on the falling edge, half a period away from the active edge.
// -----------------------------------------------------------------------------
module tb_rx_frame_controller;

    logic        clk;
    logic        rst;
    logic        baud_en;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic [15:0] display;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    rx_frame_controller dut (
        .clk       (clk),
        .rst       (rst),
        .baud_en   (baud_en),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .display   (display),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every error pulse, so long stretches without rx_rdy can be
    // checked for an early timeout.
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
    end

    // ---------------- vector table ----------------
    typedef struct {
        int             n;       // number of bytes used from b
        logic [6:0][7:0] b;      // b[6] is sent first
        logic           e_ok;
        logic           e_err;
        logic [1:0]     e_code;
        logic [15:0]    e_disp;
        logic [7:0]     e_cnt;
    } vec_t;

    vec_t vecs [0:6];

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic tick();
        baud_en = 1'b1;
        @(negedge clk);
        baud_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet_pulses(input string name);
        check({name, "_ok"},  32'(frame_ok),  32'd0);
        check({name, "_err"}, 32'(frame_err), 32'd0);
    endtask

    // ---------------- stimulus and scoreboard ----------------
    initial begin
        int base;
        logic [7:0] p;

        vecs[0] = '{5, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24, 8'h00, 8'h00}, 1'b1, 1'b0, 2'd0, 16'h1234, 8'd1};
        vecs[1] = '{5, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h25, 8'h00, 8'h00}, 1'b0, 1'b1, 2'd2, 16'h1234, 8'd1};
        vecs[2] = '{2, {8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'd1, 16'h1234, 8'd1};
        vecs[3] = '{4, {8'hA5, 8'h01, 8'h07, 8'h06, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 2'd0, 16'h0007, 8'd2};
        vecs[4] = '{7, {8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h11, 8'hB6}, 1'b1, 1'b0, 2'd0, 16'hA511, 8'd3};
        vecs[5] = '{2, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'd1, 16'hA511, 8'd3};
        vecs[6] = '{4, {8'hA5, 8'h01, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 2'd0, 16'h00FF, 8'd4};

        rst = 1'b1; baud_en = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_display", 32'(display),   32'h0);
        check("rst_cnt",     32'(frame_cnt), 32'h0);
        check("rst_code",    32'(err_code),  32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check_quiet_pulses("rst");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(vecs[i].b[6-j]);
                if (j < vecs[i].n - 1) check_quiet_pulses($sformatf("v%0d_mid%0d", i, j));
            end
            check($sformatf("v%0d_ok", i),   32'(frame_ok),  32'(vecs[i].e_ok));
            check($sformatf("v%0d_err", i),  32'(frame_err), 32'(vecs[i].e_err));
            check($sformatf("v%0d_code", i), 32'(err_code),  32'(vecs[i].e_code));
            check($sformatf("v%0d_disp", i), 32'(display),   32'(vecs[i].e_disp));
            check($sformatf("v%0d_cnt", i),  32'(frame_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_busy", i), 32'(busy),      32'd0);
            check($sformatf("v%0d_state", i), 32'(state_dbg), 32'd0);
            @(negedge clk);
            check_quiet_pulses($sformatf("v%0d_after", i));
        end

        // Timeout: 639 ticks keep the frame alive, the 640th rejects it.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
        check("to_busy_mid", 32'(busy), 32'd1);
        base = err_pulses;
        repeat (639) tick();
        check("to_no_early_err", 32'(err_pulses - base), 32'd0);
        check("to_busy_639",     32'(busy),              32'd1);
        baud_en = 1'b1;
        @(negedge clk);
        baud_en = 1'b0;
        check("to_err",   32'(frame_err), 32'd1);
        check("to_code",  32'(err_code),  32'd3);
        check("to_busy",  32'(busy),      32'd0);
        check("to_disp",  32'(display),   32'h00FF);
        @(negedge clk);
        check("to_err_width", 32'(frame_err), 32'd0);

        // Final tick coincident with a byte: the byte wins, no timeout.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
        base = err_pulses;
        repeat (639) tick();
        baud_en = 1'b1;
        send_byte(8'h34);
        baud_en = 1'b0;
        check("co_no_err", 32'(err_pulses - base), 32'd0);
        check("co_busy",   32'(busy),              32'd1);
        check("co_state",  32'(state_dbg),         32'd3);
        send_byte(8'h24);
        check("co_ok",   32'(frame_ok),  32'd1);
        check("co_disp", 32'(display),   32'h1234);
        check("co_cnt",  32'(frame_cnt), 32'd5);
        check("co_code", 32'(err_code),  32'd0);

        // Back-to-back frames with no idle gap, through the frame_cnt wrap.
        for (int k = 0; k < 251; k++) begin
            p = 8'(k);
            send_byte(8'hA5); send_byte(8'h01); send_byte(p); send_byte(8'h01 ^ p);
            check($sformatf("b2b_ok%0d", k), 32'(frame_ok), 32'd1);
            if (k == 249) check("wrap_255", 32'(frame_cnt), 32'd255);
        end
        check("wrap_0",    32'(frame_cnt), 32'd0);
        check("wrap_disp", 32'(display),   32'h00FA);

        // Reset mid-frame with non-zero outputs.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h04);
        check("pre_cnt", 32'(frame_cnt), 32'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h00);
        check("pre_code", 32'(err_code), 32'd2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
        check("pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_display", 32'(display),   32'h0);
        check("mr_cnt",     32'(frame_cnt), 32'h0);
        check("mr_code",    32'(err_code),  32'h0);
        check("mr_busy",    32'(busy),      32'h0);
        check("mr_state",   32'(state_dbg), 32'h0);
        check_quiet_pulses("mr");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09); send_byte(8'h08);
        check("pr_ok",   32'(frame_ok),  32'd1);
        check("pr_disp", 32'(display),   32'h0009);
        check("pr_cnt",  32'(frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_controller.md
# rx_frame_controller

Framing controller between the UART receiver and the seven-segment display path. It consumes the received byte stream (`rx_rdy`/`rx_data`), parses fixed-format frames (SOF, length, payload, XOR checksum), and commits verified payloads to a 16-bit display register whose four nibbles feed the four BCD-to-segment decoders. Malformed frames, checksum failures and stalled frames are rejected with an error pulse and code, and the display is left unchanged.

## Interface
- `SOF`, default 8'hA5: start-of-frame byte.
- `MAX_LEN`, default 2: maximum payload bytes; display width is 8*MAX_LEN.
- `TIMEOUT_TICKS`, default 640: `baud_en` ticks allowed between bytes inside a frame (4 byte times at 16x oversampling).
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `baud_en` in 1: 16x-baud tick, one `clk` cycle wide.
- `rx_rdy` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `display` out 8*MAX_LEN: committed payload; nibble [15:12] drives the leftmost digit.
- `frame_ok` out 1: one-cycle pulse on commit.
- `frame_err` out 1: one-cycle pulse on rejection.
- `err_code` out 2: last error; 0 none, 1 bad length, 2 checksum, 3 timeout.
- `busy` out 1: high while the FSM is not in IDLE.
- `frame_cnt` out 8: count of good frames, wraps 255 to 0.

## Operation
- States: IDLE, LEN, PAYLOAD, CHK.
- IDLE: on `rx_rdy` with `rx_data==SOF`, go to LEN. Any other byte is ignored.
- LEN: on `rx_rdy`:
  - If the byte is 0 or greater than MAX_LEN: error 1, return to IDLE.
  - Otherwise latch the length, set chk=byte, clear the shadow register and byte counter, go to PAYLOAD.
- PAYLOAD: on each `rx_rdy`:
  - shadow <= {shadow[8*MAX_LEN-9:0], byte}; chk ^= byte; count++.
  - After the length-th byte, go to CHK.
  - A byte equal to SOF is treated as data here; there is no resync.
- CHK: on `rx_rdy`:
  - If byte==chk: display <= shadow, pulse `frame_ok`, increment `frame_cnt`, set `err_code` to 0.
  - Otherwise: error 2, display unchanged.
  - In both cases return to IDLE.
- Shift order: the first payload byte ends up most significant. LEN=1 with byte B gives display = {8'h00, B}.
- Timeout:
  - The tick counter clears on every `rx_rdy` and while in IDLE.
  - Outside IDLE it increments on `baud_en`.
  - When it reaches TIMEOUT_TICKS: error 3, return to IDLE.
- Simultaneous `rx_rdy` and the final timeout tick in the same cycle: the byte is processed and no timeout occurs.
- Error action: pulse `frame_err`, latch `err_code`, return to IDLE. Shadow and chk contents become don't-care.
- `err_code` holds its value until the next `frame_err` or `frame_ok`.
- Reset (any time, including mid-frame):
  - state IDLE, display 0, `frame_ok`/`frame_err` 0, `err_code` 0, `busy` 0, `frame_cnt` 0, tick counter 0.
  - The partially received frame is discarded.

## Timing
- All outputs are registered.
- `frame_ok`/`frame_err` go high on the first `clk` edge after the `rx_rdy` cycle that completes or breaks the frame. They last exactly one cycle.
- `display`, `frame_cnt` and `err_code` update on that same edge.
- `busy` rises on the edge after the SOF `rx_rdy` and falls on the edge that returns the FSM to IDLE.
- Timeout error is flagged on the edge after the `baud_en` that makes count==TIMEOUT_TICKS.
- The block accepts a new SOF in the cycle immediately after returning to IDLE. There is no dead time.
- Throughput limit is `rx_rdy` rate only; the block never back-pressures.

## Test plan
- Good frame A5 02 12 34 24 -> after the last byte: `frame_ok` pulses once, display=16'h1234, `frame_cnt`=1, `err_code`=0, `busy` low.
- Bad checksum A5 02 12 34 25 -> `frame_err` pulse, `err_code`=2, display keeps its previous value 16'h1234.
- Bad length A5 03 -> `frame_err` on the LEN byte, `err_code`=1. The following A5 01 07 06 then yields display=16'h0007 and `frame_ok`.
- Timeout: send A5 02 12, then 640 `baud_en` ticks with no `rx_rdy` -> `frame_err`, `err_code`=3, `busy` 0. Also drive the 640th tick coincident with `rx_rdy`=34 -> no error.
- Noise and SOF-as-data: 00 FF A5 02 A5 11 B6 -> leading bytes ignored; A5 accepted as payload; display=16'hA511, `frame_ok`.
- Reset mid-frame: A5 02 12, assert `rst` -> all outputs 0 immediately. Then A5 01 09 08 -> display=16'h0009, `frame_cnt`=1.
